md_unit: RTL and testbench

- Multiply/divide unit in the E stage of the five-stage pipeline.
- Owns the HI/LO architectural registers and produces the 32-bit HILO value that the E/M pipeline register latches for MFHI/MFLO.
- Executes MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations and MTHI/MTLO as single-cycle writes.
- Exposes Busy so the hazard unit stalls F/D while an operation is in flight.

---
 rtl/md_unit_pkg.sv | 29 ++
 rtl/md_arith.sv | 60 ++++++
 rtl/md_unit.sv | 106 ++++++++++
 tb/tb_md_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit: MDOp encodings and default
// operation latencies. The control decoder and hazard unit import these too.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // True for the opcodes that occupy the unit for several cycles.
  function automatic logic md_is_multicycle(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Produces the full {hi,lo} result
// for the requested op and flags a zero divisor so the caller can suppress
// the commit.
module md_arith
  import md_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div_zero
);

  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_abs_a;
  logic [31:0]        w_abs_b;
  logic [31:0]        w_div_a;
  logic [31:0]        w_div_b;
  logic [31:0]        w_quo;
  logic [31:0]        w_rem;
  logic               w_signed_div;
  logic               w_b_zero;

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide goes through magnitudes so a single unsigned divider serves
  // both DIV and DIVU; a zero divisor is replaced by 1 to keep the divider
  // well-defined, its result is discarded downstream anyway.
  assign w_signed_div = (i_op == MD_DIV);
  assign w_b_zero     = (i_b == 32'd0);
  assign w_abs_a      = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_abs_b      = i_b[31] ? (32'd0 - i_b) : i_b;
  assign w_div_a      = w_signed_div ? w_abs_a : i_a;
  assign w_div_b      = w_b_zero ? 32'd1 : (w_signed_div ? w_abs_b : i_b);
  assign w_quo        = w_div_a / w_div_b;
  assign w_rem        = w_div_a % w_div_b;

  // Select the result for the current op and restore signs for DIV.
  always_comb begin
    o_result   = 64'd0;
    o_div_zero = 1'b0;
    case (i_op)
      MD_MULT:  o_result = w_prod_s;
      MD_MULTU: o_result = w_prod_u;
      MD_DIV: begin
        o_result[31:0]  = (i_a[31] ^ i_b[31]) ? (32'd0 - w_quo) : w_quo;
        o_result[63:32] = i_a[31] ? (32'd0 - w_rem) : w_rem;
        o_div_zero      = w_b_zero;
      end
      MD_DIVU: begin
        o_result   = {w_rem, w_quo};
        o_div_zero = w_b_zero;
      end
      default: o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage. Owns HI/LO, runs MULT/DIV variants as
// fixed-latency operations and applies MTHI/MTLO in a single cycle.
//
//   state  | meaning
//   IDLE   | no operation pending, Busy=0, Start is accepted
//   RUN    | result latched in pending, cnt counts down to the commit edge
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HILO_out
);

  localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

  md_state_e   r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_pend;
  logic        r_pend_dz;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [63:0] w_result;
  logic        w_div_zero;
  logic        w_is_div;

  md_arith u_arith (
    .i_op       (MDOp),
    .i_a        (A),
    .i_b        (B),
    .o_result   (w_result),
    .o_div_zero (w_div_zero)
  );

  assign w_is_div = (MDOp == MD_DIV) || (MDOp == MD_DIVU);

  // Control FSM: accepts requests in IDLE, counts down in RUN and commits the
  // pending result on the final edge. Requests during RUN are dropped.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_pend    <= 64'd0;
      r_pend_dz <= 1'b0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (md_is_multicycle(MDOp)) begin
              r_pend    <= w_result;
              r_pend_dz <= w_div_zero;
              r_cnt     <= w_is_div ? LP_DIV_N : LP_MULT_N;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end else if (MDOp == MD_MTHI) begin
              r_hi <= A;
            end else if (MDOp == MD_MTLO) begin
              r_lo <= A;
            end
          end
        end
        S_RUN: begin
          if (r_cnt == 4'd1) begin
            if (!r_pend_dz) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign Busy     = r_busy;
  assign HI       = r_hi;
  assign LO       = r_lo;
  assign HILO_out = HiLoSel ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_unit_pkg::*;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        HiLoSel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] HILO_out;

  int n_checks;
  int n_fail;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .MDOp     (MDOp),
    .A        (A),
    .B        (B),
    .HiLoSel  (HiLoSel),
    .Busy     (Busy),
    .HI       (HI),
    .LO       (LO),
    .HILO_out (HILO_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive a one-cycle request; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0; MDOp = MD_NONE;
  endtask

  task automatic test_reset();
    Rst = 1'b0; Start = 1'b0; MDOp = MD_NONE; A = 0; B = 0; HiLoSel = 1'b0;
    #12;
    n_checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0 || HILO_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: HI=%h LO=%h Busy=%b HILO=%h, required all zero", HI, LO, Busy, HILO_out);
    end
    @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_mult();
    int n; int early;
    issue(MD_MULT, 32'hFFFFFFFF, 32'h00000002);
    n = 0; early = 0;
    while (Busy === 1'b1 && n < 20) begin
      if (HI !== 32'd0 || LO !== 32'd0) early++;
      @(posedge Clk); #1; n++;
    end
    n_checks++;
    if (n !== 5 || early !== 0) begin
      n_fail++;
      $display("FAIL mult_busy: busy cycles=%0d early=%0d, required 5 and 0", n, early);
    end
    n_checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL mult_result: HI=%h LO=%h, required ffffffff fffffffe", HI, LO);
    end
  endtask

  task automatic test_multu();
    int n;
    issue(MD_MULTU, 32'hFFFFFFFF, 32'h00000002);
    n = 0;
    while (Busy === 1'b1 && n < 20) begin @(posedge Clk); #1; n++; end
    n_checks++;
    if (n !== 5 || HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL multu: cycles=%0d HI=%h LO=%h, required 5 00000001 fffffffe", n, HI, LO);
    end
  endtask

  task automatic test_div();
    int n; int early;
    issue(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
    n = 0; early = 0;
    while (Busy === 1'b1 && n < 20) begin
      if (HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) early++;
      @(posedge Clk); #1; n++;
    end
    n_checks++;
    if (n !== 10 || early !== 0) begin
      n_fail++;
      $display("FAIL div_busy: busy cycles=%0d early=%0d, required 10 and 0", n, early);
    end
    n_checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      n_fail++;
      $display("FAIL div_result: HI=%h LO=%h, required ffffffff fffffffd", HI, LO);
    end
    issue(MD_DIVU, 32'd100, 32'd7);
    n = 0;
    while (Busy === 1'b1 && n < 20) begin @(posedge Clk); #1; n++; end
    n_checks++;
    if (n !== 10 || HI !== 32'd2 || LO !== 32'd14) begin
      n_fail++;
      $display("FAIL divu_result: cycles=%0d HI=%h LO=%h, required 10 00000002 0000000e", n, HI, LO);
    end
  endtask

  task automatic test_div_zero();
    int n;
    issue(MD_MTHI, 32'h11, 32'h0);
    issue(MD_MTLO, 32'h22, 32'h0);
    issue(MD_DIVU, 32'd7, 32'd0);
    n = 0;
    while (Busy === 1'b1 && n < 20) begin @(posedge Clk); #1; n++; end
    n_checks++;
    if (n !== 10 || HI !== 32'h11 || LO !== 32'h22) begin
      n_fail++;
      $display("FAIL divu_zero: cycles=%0d HI=%h LO=%h, required 10 00000011 00000022", n, HI, LO);
    end
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    n = 0;
    while (Busy === 1'b1 && n < 20) begin @(posedge Clk); #1; n++; end
    n_checks++;
    if (n !== 10 || HI !== 32'h0 || LO !== 32'h80000000) begin
      n_fail++;
      $display("FAIL div_overflow: cycles=%0d HI=%h LO=%h, required 10 00000000 80000000", n, HI, LO);
    end
  endtask

  task automatic test_mt_mux();
    issue(MD_MTHI, 32'hDEADBEEF, 32'h0);
    n_checks++;
    if (HI !== 32'hDEADBEEF || Busy !== 1'b0 || LO !== 32'h80000000) begin
      n_fail++;
      $display("FAIL mthi: HI=%h Busy=%b LO=%h, required deadbeef 0 80000000", HI, Busy, LO);
    end
    HiLoSel = 1'b1; #1;
    n_checks++;
    if (HILO_out !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL hilo_sel_hi: HILO_out=%h, required deadbeef", HILO_out);
    end
    HiLoSel = 1'b0; #1;
    n_checks++;
    if (HILO_out !== 32'h80000000) begin
      n_fail++;
      $display("FAIL hilo_sel_lo: HILO_out=%h, required 80000000", HILO_out);
    end
    issue(MD_MTLO, 32'h12345678, 32'h0);
    n_checks++;
    if (LO !== 32'h12345678 || HILO_out !== 32'h12345678 || Busy !== 1'b0 || HI !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL mtlo: LO=%h HILO=%h Busy=%b HI=%h, required 12345678 12345678 0 deadbeef", LO, HILO_out, Busy, HI);
    end
    // Reserved opcode and NONE with Start must leave state untouched.
    issue(MD_RSVD, 32'hFFFF0000, 32'h1);
    issue(MD_NONE, 32'hFFFF0000, 32'h1);
    n_checks++;
    if (LO !== 32'h12345678 || HI !== 32'hDEADBEEF || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nop_ops: HI=%h LO=%h Busy=%b, required deadbeef 12345678 0", HI, LO, Busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(MD_MULT, 32'd6, 32'd7);
    n = 0;
    while (Busy === 1'b1 && n < 20) begin
      if (n == 1) begin
        Start = 1'b1; MDOp = MD_DIVU; A = 32'd100; B = 32'd3;
      end else if (n == 2) begin
        Start = 1'b1; MDOp = MD_MTHI; A = 32'hAAAAAAAA; B = 32'd0;
      end else begin
        Start = 1'b0; MDOp = MD_NONE;
      end
      @(posedge Clk); #1; n++;
    end
    Start = 1'b0; MDOp = MD_NONE;
    n_checks++;
    if (n !== 5 || HI !== 32'd0 || LO !== 32'd42) begin
      n_fail++;
      $display("FAIL ignore_busy: cycles=%0d HI=%h LO=%h, required 5 00000000 0000002a", n, HI, LO);
    end
    @(posedge Clk); #1;
    n_checks++;
    if (Busy !== 1'b0 || LO !== 32'd42) begin
      n_fail++;
      $display("FAIL ignore_busy_after: Busy=%b LO=%h, required 0 0000002a", Busy, LO);
    end
  endtask

  task automatic test_async_reset();
    int n; int bad;
    issue(MD_MTHI, 32'h55, 32'h0);
    issue(MD_DIV, 32'd100, 32'd5);
    repeat (3) begin @(posedge Clk); #1; end
    #2; Rst = 1'b0; #1;
    n_checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: HI=%h LO=%h Busy=%b, required 0 0 0", HI, LO, Busy);
    end
    @(negedge Clk); Rst = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL no_commit_after_reset: bad cycles=%0d, required 0", bad);
    end
    issue(MD_MULT, 32'd3, 32'd4);
    n = 0;
    while (Busy === 1'b1 && n < 20) begin @(posedge Clk); #1; n++; end
    n_checks++;
    if (n !== 5 || HI !== 32'd0 || LO !== 32'd12) begin
      n_fail++;
      $display("FAIL mult_after_reset: cycles=%0d HI=%h LO=%h, required 5 00000000 0000000c", n, HI, LO);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_mt_mux();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
